// File: rtl/rf_write_arbiter_if.sv
// Writeback, reservation, hazard-check and register-file-write signals of rf_write_arbiter.
// Forwarding read ports exist only when RF_ARB_FWD_EN is defined.
interface rf_write_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              wb0_valid;
    logic [ADDR_W-1:0] wb0_rd;
    logic [DATA_W-1:0] wb0_data;
    logic              wb0_ready;
    logic              wb1_valid;
    logic [ADDR_W-1:0] wb1_rd;
    logic [DATA_W-1:0] wb1_data;
    logic              wb1_ready;
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_rd;
    logic              rsv_ready;
    logic [ADDR_W-1:0] chk_rs;
    logic [ADDR_W-1:0] chk_rt;
    logic              stall;
    logic              rf_rw;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_rd_data;
    logic              orphan_err;
`ifdef RF_ARB_FWD_EN
    logic [DATA_W-1:0] rf_rs_data;
    logic [DATA_W-1:0] rf_rt_data;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
`endif

    modport master (
        output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
               rsv_valid, rsv_rd, chk_rs, chk_rt,
        input  wb0_ready, wb1_ready, rsv_ready, stall, rf_rw, rf_rd, rf_rd_data, orphan_err
`ifdef RF_ARB_FWD_EN
        , output rf_rs_data, rf_rt_data
        , input  rs_data, rt_data
`endif
    );

    modport slave (
        input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
               rsv_valid, rsv_rd, chk_rs, chk_rt,
        output wb0_ready, wb1_ready, rsv_ready, stall, rf_rw, rf_rd, rf_rd_data, orphan_err
`ifdef RF_ARB_FWD_EN
        , input  rf_rs_data, rf_rt_data
        , output rs_data, rt_data
`endif
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register file write port plus a per-register pending-write scoreboard.
// Optional feature macro RF_ARB_FWD_EN: forward the output-stage write to decode reads and stall one cycle less.
module rf_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    rf_write_arbiter_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    logic              prio_q, prio_d;
    logic [NREG-1:0]   busy_q, busy_d, busy_eff;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              orphan_q, orphan_d;
    logic              gnt0, gnt1, gnt, rsv_fire;
    logic [ADDR_W-1:0] g_rd;
    logic [DATA_W-1:0] g_data;

    // Every output is forced low while reset is held, including the combinational handshakes.
    always_comb begin
        gnt0   = reset && bus.wb0_valid && (!bus.wb1_valid || !prio_q);
        gnt1   = reset && bus.wb1_valid && (!bus.wb0_valid || prio_q);
        gnt    = gnt0 || gnt1;
        g_rd   = gnt1 ? bus.wb1_rd   : bus.wb0_rd;
        g_data = gnt1 ? bus.wb1_data : bus.wb0_data;
    end

    assign bus.wb0_ready  = gnt0;
    assign bus.wb1_ready  = gnt1;
    assign bus.rsv_ready  = reset && ((bus.rsv_rd == '0) || !busy_q[bus.rsv_rd]);
    assign rsv_fire       = bus.rsv_valid && bus.rsv_ready;
    assign bus.stall      = reset && (busy_eff[bus.chk_rs] || busy_eff[bus.chk_rt]);
    assign bus.rf_rw      = rw_q;
    assign bus.rf_rd      = rd_q;
    assign bus.rf_rd_data = data_q;
    assign bus.orphan_err = orphan_q;

    assign busy_d[0]   = 1'b0;
    assign busy_eff[0] = 1'b0;

    // A commit clears its bit on the same edge the file takes the data; clear beats a new reservation.
    for (genvar r = 1; r < NREG; r++) begin : g_sb
        logic clr;
        assign clr       = rw_q && (rd_q == ADDR_W'(r));
        assign busy_d[r] = !clr && (busy_q[r] || (rsv_fire && (bus.rsv_rd == ADDR_W'(r))));
`ifdef RF_ARB_FWD_EN
        assign busy_eff[r] = busy_q[r] && !clr;
`else
        assign busy_eff[r] = busy_q[r];
`endif
    end

`ifdef RF_ARB_FWD_EN
    assign bus.rs_data = !reset ? '0 :
        (rw_q && bus.chk_rs == rd_q && bus.chk_rs != '0) ? data_q : bus.rf_rs_data;
    assign bus.rt_data = !reset ? '0 :
        (rw_q && bus.chk_rt == rd_q && bus.chk_rt != '0) ? data_q : bus.rf_rt_data;
`endif

    always_comb begin
        prio_d   = prio_q;
        rw_d     = 1'b0;
        rd_d     = rd_q;
        data_d   = data_q;
        orphan_d = orphan_q;
        if (gnt) begin
            prio_d = gnt0;  // point at the requester that lost
            rw_d   = (g_rd != '0);
            rd_d   = g_rd;
            data_d = g_data;
            if (g_rd != '0 && !busy_q[g_rd])
                orphan_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q   <= 1'b0;
            busy_q   <= '0;
            rw_q     <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
            orphan_q <= 1'b0;
        end else begin
            prio_q   <= prio_d;
            busy_q   <= busy_d;
            rw_q     <= rw_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            orphan_q <= orphan_d;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: directed scenarios then random traffic against a cycle-level model.
module tb_rf_write_arbiter;
    localparam int DW = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rf_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
    rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int       cyc;
        bit       r0, r1, rsvr, stall, rw, orph;
        bit [2:0] rd;
        bit [7:0] data, rs, rt;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   nvec = 0, nerr = 0, ncyc = 0;

    // Model state: which registers await a write, whose turn it is, and the write heading to the file.
    bit       pend[8];
    bit       turn;
    bit       st_rw, m_orph;
    bit [2:0] st_rd;
    bit [7:0] st_data;

    function automatic bit hz(bit [2:0] r);
        if (r == 0) return 1'b0;
`ifdef RF_ARB_FWD_EN
        if (st_rw && st_rd == r) return 1'b0;
`endif
        return pend[r];
    endfunction

    task automatic cyc();
        exp_t     e;
        bit       nb[8];
        bit       nt, nrw, norph;
        bit [2:0] nrd, grd;
        bit [7:0] ndata, gdata;
        int       winner;
        e = '{default: 0};
        e.cyc = ncyc;
        nb = '{default: 0};
        nt = 0; nrw = 0; nrd = 0; ndata = 0; norph = 0;
        if (reset) begin
            winner = -1;
            if (bus.wb0_valid && bus.wb1_valid) winner = int'(turn);
            else if (bus.wb0_valid)             winner = 0;
            else if (bus.wb1_valid)             winner = 1;
            e.r0    = (winner == 0);
            e.r1    = (winner == 1);
            e.rsvr  = (bus.rsv_rd == 0) || !pend[bus.rsv_rd];
            e.stall = hz(bus.chk_rs) || hz(bus.chk_rt);
            e.rw    = st_rw;
            e.rd    = st_rd;
            e.data  = st_data;
            e.orph  = m_orph;
`ifdef RF_ARB_FWD_EN
            e.rs = (st_rw && bus.chk_rs == st_rd && bus.chk_rs != 0) ? st_data : bus.rf_rs_data;
            e.rt = (st_rw && bus.chk_rt == st_rd && bus.chk_rt != 0) ? st_data : bus.rf_rt_data;
`endif
            nb = pend;
            if (bus.rsv_valid && e.rsvr && bus.rsv_rd != 0) nb[bus.rsv_rd] = 1'b1;
            if (st_rw) nb[st_rd] = 1'b0;
            nt = turn; nrd = st_rd; ndata = st_data; norph = m_orph;
            if (winner >= 0) begin
                grd   = (winner == 1) ? bus.wb1_rd   : bus.wb0_rd;
                gdata = (winner == 1) ? bus.wb1_data : bus.wb0_data;
                if (grd != 0 && !pend[grd]) norph = 1'b1;
                nrw = (grd != 0); nrd = grd; ndata = gdata;
                nt = (winner == 0);
            end
            nb[0] = 1'b0;
        end
        q.push_back(e);
        last = e;
        @(posedge clk);
        pend = nb; turn = nt; st_rw = nrw; st_rd = nrd; st_data = ndata; m_orph = norph;
        ncyc++;
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp, int c);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wb0_ready",  32'(bus.wb0_ready),  32'(e.r0),    e.cyc);
                chk("wb1_ready",  32'(bus.wb1_ready),  32'(e.r1),    e.cyc);
                chk("rsv_ready",  32'(bus.rsv_ready),  32'(e.rsvr),  e.cyc);
                chk("stall",      32'(bus.stall),      32'(e.stall), e.cyc);
                chk("rf_rw",      32'(bus.rf_rw),      32'(e.rw),    e.cyc);
                chk("rf_rd",      32'(bus.rf_rd),      32'(e.rd),    e.cyc);
                chk("rf_rd_data", 32'(bus.rf_rd_data), 32'(e.data),  e.cyc);
                chk("orphan_err", 32'(bus.orphan_err), 32'(e.orph),  e.cyc);
`ifdef RF_ARB_FWD_EN
                chk("rs_data",    32'(bus.rs_data),    32'(e.rs),    e.cyc);
                chk("rt_data",    32'(bus.rt_data),    32'(e.rt),    e.cyc);
`endif
            end
        end
    end

    task automatic idle();
        bus.wb0_valid = 0; bus.wb0_rd = 0; bus.wb0_data = 0;
        bus.wb1_valid = 0; bus.wb1_rd = 0; bus.wb1_data = 0;
        bus.rsv_valid = 0; bus.rsv_rd = 0;
        bus.chk_rs = 0; bus.chk_rt = 0;
`ifdef RF_ARB_FWD_EN
        bus.rf_rs_data = 0; bus.rf_rt_data = 0;
`endif
    endtask

    function automatic bit [2:0] pick_rd();
        bit [2:0] r;
        r = 3'($urandom_range(0, 7));
        // Bias towards reserved registers so commits and stalls actually happen.
        for (int k = 0; k < 4 && !pend[r]; k++) r = 3'($urandom_range(0, 7));
        return r;
    endfunction

    initial begin
        pend = '{default: 0};
        turn = 0; st_rw = 0; st_rd = 0; st_data = 0; m_orph = 0;
        last = '{default: 0};
        idle();
        reset = 1'b0;
        @(posedge clk); #1;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();

        // Both requesters valid: expect 0,1,0,1.
        bus.wb0_valid = 1; bus.wb0_rd = 0; bus.wb0_data = 8'h11;
        bus.wb1_valid = 1; bus.wb1_rd = 0; bus.wb1_data = 8'h22;
        repeat (4) cyc();
        idle();

        // Reserve r3, write A5 with decode reading r3.
        bus.rsv_valid = 1; bus.rsv_rd = 3;
        cyc();
        bus.rsv_valid = 0; bus.chk_rs = 3;
`ifdef RF_ARB_FWD_EN
        bus.rf_rs_data = 8'h5C;
`endif
        bus.wb0_valid = 1; bus.wb0_rd = 3; bus.wb0_data = 8'hA5;
        cyc();
        bus.wb0_valid = 0;
        repeat (3) cyc();
        idle();

        // Busy r5 refuses a second reservation until its write commits.
        bus.rsv_valid = 1; bus.rsv_rd = 5;
        cyc();
        bus.wb1_valid = 1; bus.wb1_rd = 5; bus.wb1_data = 8'h5A;
        cyc();
        bus.wb1_valid = 0;
        repeat (2) cyc();
        bus.rsv_valid = 0;
        bus.wb0_valid = 1; bus.wb0_rd = 5; bus.wb0_data = 8'h77;
        cyc();
        bus.wb0_valid = 0;
        repeat (2) cyc();

        // Write to r0: granted, no file write, no orphan.
        bus.wb1_valid = 1; bus.wb1_rd = 0; bus.wb1_data = 8'hFF;
        cyc();
        bus.wb1_valid = 0;
        cyc();

        // Unreserved r2: orphan flag sets and sticks.
        bus.wb0_valid = 1; bus.wb0_rd = 2; bus.wb0_data = 8'h33;
        cyc();
        bus.wb0_valid = 0;
        repeat (2) cyc();

        for (int i = 0; i < 1500; i++) begin
            if (!(bus.wb0_valid && !last.r0)) begin
                bus.wb0_valid = ($urandom_range(0, 99) < 60);
                bus.wb0_rd = pick_rd(); bus.wb0_data = 8'($urandom);
            end
            if (!(bus.wb1_valid && !last.r1)) begin
                bus.wb1_valid = ($urandom_range(0, 99) < 60);
                bus.wb1_rd = pick_rd(); bus.wb1_data = 8'($urandom);
            end
            bus.rsv_valid = ($urandom_range(0, 99) < 50);
            bus.rsv_rd = 3'($urandom_range(0, 7));
            bus.chk_rs = 3'($urandom_range(0, 7));
            bus.chk_rt = 3'($urandom_range(0, 7));
`ifdef RF_ARB_FWD_EN
            bus.rf_rs_data = 8'($urandom); bus.rf_rt_data = 8'($urandom);
`endif
            cyc();
        end
        idle();
        repeat (3) cyc();

        // Fill the scoreboard, start a write, then pull reset while rf_rw is high.
        for (int r = 1; r < 8; r++) begin
            bus.rsv_valid = 1; bus.rsv_rd = 3'(r);
            cyc();
        end
        bus.rsv_valid = 0;
        bus.wb0_valid = 1; bus.wb0_rd = 4; bus.wb0_data = 8'hC3;
        cyc();
        idle();
        reset = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        for (int r = 0; r < 8; r++) begin
            bus.rsv_rd = 3'(r); bus.chk_rs = 3'(r);
            cyc();
        end
        idle();
        cyc();

        if (q.size() != 0) begin
            nerr++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
